// File: rtl/spi_arbiter.sv
// Round-robin arbiter sharing one spi_serdes engine between the init sequencer,
// the periodic axis reader and the host register port, with a BUSY watchdog.
module spi_arbiter #(
  parameter int TIMEOUT_CYCLES = 64,
  parameter int CNT_W          = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [2:0]  req,
  input  logic [15:0] req_tx0,
  input  logic [15:0] req_tx1,
  input  logic [15:0] req_tx2,
  output logic [2:0]  ack,
  output logic [2:0]  err,
  output logic [7:0]  rd_data,
  output logic        busy,
  output logic [1:0]  grant_id,
  output logic        serdes_start,
  output logic [15:0] serdes_tx,
  input  logic        serdes_done,
  input  logic [7:0]  serdes_rx
);

  typedef enum logic [1:0] {
    IDLE,
    BUSY,
    RELEASE
  } state_t;

  localparam bit              WD_EN   = (TIMEOUT_CYCLES != 0);
  localparam logic [CNT_W-1:0] WD_LAST = CNT_W'((TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0);

  state_t           state;
  logic [1:0]       last;
  logic [CNT_W-1:0] watchdog;

  logic [1:0]  order0, order1, order2;
  logic [1:0]  winner;
  logic [15:0] winner_tx;

  // Search order starts just after the last winner and wraps modulo 3.
  always_comb begin
    // NOTE: every combinational output gets a value on every path, so no latch is inferred.
    order0    = 2'd0;
    order1    = 2'd1;
    order2    = 2'd2;
    winner    = 2'd0;
    winner_tx = req_tx0;
    case (last)
      2'd0: begin order0 = 2'd1; order1 = 2'd2; order2 = 2'd0; end
      2'd1: begin order0 = 2'd2; order1 = 2'd0; order2 = 2'd1; end
      default: begin order0 = 2'd0; order1 = 2'd1; order2 = 2'd2; end
    endcase
    if (req[order0])      winner = order0;
    else if (req[order1]) winner = order1;
    else                  winner = order2;
    case (winner)
      2'd0:    winner_tx = req_tx0;
      2'd1:    winner_tx = req_tx1;
      default: winner_tx = req_tx2;
    endcase
  end

  assign busy = (state != IDLE);

  always_ff @(posedge clk) begin
    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    if (reset) begin
      state        <= IDLE;
      last         <= 2'd2;
      watchdog     <= '0;
      serdes_start <= 1'b0;
      serdes_tx    <= '0;
      ack          <= '0;
      err          <= '0;
      rd_data      <= '0;
      grant_id     <= 2'd0;
    end else begin
      ack <= '0;
      err <= '0;
      case (state)
        IDLE: begin
          if (req != 3'b000) begin
            grant_id     <= winner;
            last         <= winner;
            serdes_tx    <= winner_tx;
            serdes_start <= 1'b1;
            watchdog     <= '0;
            state        <= BUSY;
          end
        end
        BUSY: begin
          // A done arriving on the final watchdog cycle still completes normally.
          if (serdes_done) begin
            serdes_start <= 1'b0;
            rd_data      <= serdes_rx;
            ack          <= 3'b001 << grant_id;
            state        <= RELEASE;
          end else if (WD_EN && (watchdog == WD_LAST)) begin
            serdes_start <= 1'b0;
            err          <= 3'b001 << grant_id;
            state        <= RELEASE;
          end else if (watchdog != '1) begin
            watchdog <= watchdog + CNT_W'(1);
          end
        end
        RELEASE: begin
          if (!serdes_done) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_spi_arbiter.sv
// Self-checking bench for spi_arbiter: one instance with the default watchdog,
// one with an 8-cycle watchdog, compared against a round-robin reference model.
module tb_spi_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic [2:0]  req;
  logic [15:0] req_tx [3];
  logic        serdes_done;
  logic [7:0]  serdes_rx;

  logic [2:0]  a_ack, a_err, b_ack, b_err;
  logic [7:0]  a_rd_data, b_rd_data;
  logic        a_busy, b_busy, a_start, b_start;
  logic [1:0]  a_grant_id, b_grant_id;
  logic [15:0] a_tx, b_tx;

  logic [2:0]  o_ack, o_err;
  logic [7:0]  o_rd_data;
  logic        o_busy, o_start;
  logic [1:0]  o_grant_id;
  logic [15:0] o_tx;

  int sel = 0;
  int n_checks = 0;
  int n_fail = 0;
  int m_last = 2;

  always #5 clk = ~clk;

  spi_arbiter #(.TIMEOUT_CYCLES(64), .CNT_W(16)) dut_a (
    .clk(clk), .reset(reset), .req(req),
    .req_tx0(req_tx[0]), .req_tx1(req_tx[1]), .req_tx2(req_tx[2]),
    .ack(a_ack), .err(a_err), .rd_data(a_rd_data), .busy(a_busy),
    .grant_id(a_grant_id), .serdes_start(a_start), .serdes_tx(a_tx),
    .serdes_done(serdes_done), .serdes_rx(serdes_rx)
  );

  spi_arbiter #(.TIMEOUT_CYCLES(8), .CNT_W(8)) dut_b (
    .clk(clk), .reset(reset), .req(req),
    .req_tx0(req_tx[0]), .req_tx1(req_tx[1]), .req_tx2(req_tx[2]),
    .ack(b_ack), .err(b_err), .rd_data(b_rd_data), .busy(b_busy),
    .grant_id(b_grant_id), .serdes_start(b_start), .serdes_tx(b_tx),
    .serdes_done(serdes_done), .serdes_rx(serdes_rx)
  );

  always_comb begin
    if (sel == 1) begin
      o_ack = b_ack; o_err = b_err; o_rd_data = b_rd_data; o_busy = b_busy;
      o_start = b_start; o_grant_id = b_grant_id; o_tx = b_tx;
    end else begin
      o_ack = a_ack; o_err = a_err; o_rd_data = a_rd_data; o_busy = a_busy;
      o_start = a_start; o_grant_id = a_grant_id; o_tx = a_tx;
    end
  end

  // Reference arbitration: first requester found scanning from last+1, modulo 3.
  function automatic int rr_pick(input logic [2:0] r);
    for (int k = 1; k <= 3; k++) begin
      if (r[(m_last + k) % 3]) return (m_last + k) % 3;
    end
    return -1;
  endfunction

  task automatic apply_reset();
    @(negedge clk);
    reset = 1'b1; req = 3'b000; serdes_done = 1'b0; serdes_rx = 8'h00;
    @(negedge clk);
    reset = 1'b0;
    m_last = 2;
  endtask

  task automatic randomize_tx();
    for (int i = 0; i < 3; i++) req_tx[i] = 16'($urandom);
  endtask

  // Drives one transaction: wait for the grant, answer after dly cycles with rx.
  task automatic txn(input logic [2:0] r, input int dly, input logic [7:0] rx, input string name);
    int exp_id;
    int cnt;
    logic held;
    req = r;
    cnt = 0;
    while (!o_start && cnt < 8) begin
      @(negedge clk);
      cnt++;
    end
    exp_id = rr_pick(r);
    n_checks++;
    if (o_start !== 1'b1) begin
      n_fail++;
      $display("FAIL %s grant: serdes_start=%b after %0d cycles, required 1", name, o_start, cnt);
      return;
    end
    m_last = exp_id;
    n_checks++;
    if (o_grant_id !== 2'(exp_id) || o_tx !== req_tx[exp_id]) begin
      n_fail++;
      $display("FAIL %s winner: grant_id=%0d tx=%h, required %0d tx=%h",
               name, o_grant_id, o_tx, exp_id, req_tx[exp_id]);
    end
    held = 1'b1;
    repeat (dly - 1) begin
      @(negedge clk);
      if (o_start !== 1'b1 || o_ack !== 3'b000 || o_err !== 3'b000) held = 1'b0;
    end
    n_checks++;
    if (!held) begin
      n_fail++;
      $display("FAIL %s hold: start dropped or pulse seen before done, required steady start", name);
    end
    serdes_done = 1'b1;
    serdes_rx = rx;
    @(negedge clk);
    n_checks++;
    if (o_ack !== 3'(1 << exp_id) || o_err !== 3'b000 || o_rd_data !== rx || o_start !== 1'b0) begin
      n_fail++;
      $display("FAIL %s done: ack=%b err=%b rd=%h start=%b, required ack=%b err=000 rd=%h start=0",
               name, o_ack, o_err, o_rd_data, o_start, 3'(1 << exp_id), rx);
    end
    serdes_done = 1'b0;
  endtask

  task automatic test_reset();
    sel = 0;
    randomize_tx();
    @(negedge clk);
    reset = 1'b1; req = 3'b111; serdes_done = 1'b0; serdes_rx = 8'hFF;
    @(negedge clk);
    n_checks++;
    if ({o_start, o_tx, o_ack, o_err, o_rd_data, o_busy, o_grant_id} !== 35'd0) begin
      n_fail++;
      $display("FAIL reset_values: start=%b tx=%h ack=%b err=%b rd=%h busy=%b gid=%0d, required all 0",
               o_start, o_tx, o_ack, o_err, o_rd_data, o_busy, o_grant_id);
    end
    req = 3'b000;
    reset = 1'b0;
    m_last = 2;
  endtask

  task automatic test_single();
    sel = 0;
    apply_reset();
    randomize_tx();
    req_tx[1] = 16'hB200;
    req = 3'b010;
    @(negedge clk);
    n_checks++;
    if (o_start !== 1'b1 || o_tx !== 16'hB200 || o_grant_id !== 2'd1 || o_busy !== 1'b1) begin
      n_fail++;
      $display("FAIL single_grant: start=%b tx=%h gid=%0d busy=%b, required 1 B200 1 1",
               o_start, o_tx, o_grant_id, o_busy);
    end
    req = 3'b000;
    repeat (19) @(negedge clk);
    serdes_done = 1'b1;
    serdes_rx = 8'h5A;
    @(negedge clk);
    n_checks++;
    if (o_ack !== 3'b010 || o_err !== 3'b000 || o_rd_data !== 8'h5A || o_start !== 1'b0) begin
      n_fail++;
      $display("FAIL single_ack: ack=%b err=%b rd=%h start=%b, required 010 000 5a 0",
               o_ack, o_err, o_rd_data, o_start);
    end
    @(negedge clk);
    n_checks++;
    if (o_ack !== 3'b000 || o_busy !== 1'b1) begin
      n_fail++;
      $display("FAIL single_pulse: ack=%b busy=%b, required 000 1", o_ack, o_busy);
    end
    serdes_done = 1'b0;
    @(negedge clk);
    n_checks++;
    if (o_busy !== 1'b0 || o_rd_data !== 8'h5A) begin
      n_fail++;
      $display("FAIL single_idle: busy=%b rd=%h, required 0 5a", o_busy, o_rd_data);
    end
  endtask

  task automatic test_round_robin();
    sel = 0;
    apply_reset();
    randomize_tx();
    for (int i = 0; i < 6; i++) begin
      txn(3'b111, $urandom_range(1, 12), 8'($urandom), "round_robin");
    end
  endtask

  task automatic test_random_requests();
    sel = 0;
    apply_reset();
    for (int i = 0; i < 12; i++) begin
      randomize_tx();
      txn(3'($urandom_range(1, 7)), $urandom_range(1, 25), 8'($urandom), "random_req");
    end
  endtask

  task automatic test_timeout();
    int cnt;
    sel = 1;
    apply_reset();
    randomize_tx();
    txn(3'b001, 3, 8'hC3, "timeout_pre");
    req = 3'b100;
    cnt = 0;
    while (!o_start && cnt < 8) begin
      @(negedge clk);
      cnt++;
    end
    n_checks++;
    if (o_start !== 1'b1 || o_grant_id !== 2'd2) begin
      n_fail++;
      $display("FAIL timeout_grant: start=%b gid=%0d, required 1 2", o_start, o_grant_id);
    end
    m_last = 2;
    req = 3'b000;
    cnt = 0;
    while (o_start && cnt < 20) begin
      cnt++;
      @(negedge clk);
    end
    n_checks++;
    if (cnt != 8) begin
      n_fail++;
      $display("FAIL timeout_len: start high %0d cycles, required 8", cnt);
    end
    n_checks++;
    if (o_err !== 3'b100 || o_ack !== 3'b000 || o_rd_data !== 8'hC3) begin
      n_fail++;
      $display("FAIL timeout_err: err=%b ack=%b rd=%h, required 100 000 c3", o_err, o_ack, o_rd_data);
    end
    @(negedge clk);
    n_checks++;
    if (o_err !== 3'b000 || o_ack !== 3'b000) begin
      n_fail++;
      $display("FAIL timeout_pulse: err=%b ack=%b, required 000 000", o_err, o_ack);
    end
    txn(3'b011, 4, 8'h3C, "timeout_next");
  endtask

  task automatic test_done_at_timeout();
    sel = 1;
    apply_reset();
    randomize_tx();
    txn(3'b010, 8, 8'h77, "done_at_limit");
    txn(3'b110, 8, 8'h88, "done_at_limit2");
  endtask

  task automatic test_release_hold();
    int cnt;
    logic quiet;
    sel = 0;
    apply_reset();
    randomize_tx();
    req = 3'b001;
    cnt = 0;
    while (!o_start && cnt < 8) begin
      @(negedge clk);
      cnt++;
    end
    m_last = 0;
    repeat (2) @(negedge clk);
    serdes_done = 1'b1;
    serdes_rx = 8'h96;
    quiet = 1'b1;
    repeat (5) begin
      @(negedge clk);
      if (o_start !== 1'b0 || o_busy !== 1'b1) quiet = 1'b0;
    end
    serdes_done = 1'b0;
    @(negedge clk);
    if (o_start !== 1'b0) quiet = 1'b0;
    n_checks++;
    if (!quiet || o_rd_data !== 8'h96) begin
      n_fail++;
      $display("FAIL release_hold: new start while done high, rd=%h, required no start rd=96", o_rd_data);
    end
    @(negedge clk);
    n_checks++;
    if (o_start !== 1'b1 || o_grant_id !== 2'd0) begin
      n_fail++;
      $display("FAIL release_regrant: start=%b gid=%0d, required 1 0", o_start, o_grant_id);
    end
    txn(3'b001, 5, 8'h69, "release_next");
  endtask

  task automatic test_reset_mid_busy();
    int cnt;
    sel = 0;
    apply_reset();
    randomize_tx();
    req = 3'b110;
    cnt = 0;
    while (!o_start && cnt < 8) begin
      @(negedge clk);
      cnt++;
    end
    repeat (9) @(negedge clk);
    serdes_done = 1'b0;
    reset = 1'b1;
    @(negedge clk);
    n_checks++;
    if (o_start !== 1'b0 || o_ack !== 3'b000 || o_err !== 3'b000 || o_busy !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_mid_busy: start=%b ack=%b err=%b busy=%b, required 0 000 000 0",
               o_start, o_ack, o_err, o_busy);
    end
    reset = 1'b0;
    m_last = 2;
    txn(3'b111, 6, 8'hE1, "post_reset");
  endtask

  initial begin
    reset = 1'b1;
    req = 3'b000;
    serdes_done = 1'b0;
    serdes_rx = 8'h00;
    for (int i = 0; i < 3; i++) req_tx[i] = 16'h0000;
    test_reset();
    test_single();
    test_round_robin();
    test_random_requests();
    test_timeout();
    test_done_at_timeout();
    test_release_hold();
    test_reset_mid_busy();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL global_timeout: bench did not complete in time");
    $fatal(1);
  end

endmodule
